byte_enabled_sdp_bram: RTL and testbench
========================================

// Module: byte_enabled_sdp_bram
// PURPOSE
//   Byte-enabled semi-dual-port block RAM: 2**AddressBitWidth words of 32 bits.
//   One shared address per cycle. Per-byte write enables. Registered read port.
//   Storage primitive for the cache: one instance holds tag+flags, eight hold the line columns.
//   Maps onto FPGA block RAM. No reset of the array contents.
// PARAMETERS
//   AddressBitWidth  8  word address width; depth = 2**AddressBitWidth words
// PORTS
//   clk           in   1                clock; all activity on rising edge
//   rst           in   1                asynchronous, active-high reset (clears output register only)
//   write_enable  in   4                byte write enables; bit i writes data_in[8*i+7:8*i]
//   address       in   AddressBitWidth  word address for both the write and the read
//   data_in       in   32               write data
//   data_out      out  32               registered read data
// BEHAVIOUR
//   - Interface: one clock (clk); reset is asynchronous and active-high (rst).
//   - Memory array:
//     - Power-up/initial contents are all zeros. The cache relies on this for the valid/dirty bits.
//     - rst never alters the array.
//   - Reset: while rst=1, data_out = 32'h0, asynchronously on assertion. Writes are ignored while rst=1.
//   - Write, on a rising clk edge with rst=0: for each i in 0..3 where write_enable[i]=1,
//     mem[address] byte i <= data_in byte i. Bytes with write_enable[i]=0 keep their old value.
//   - Read:
//     - Latency is 1 cycle.
//     - On every rising clk edge with rst=0, data_out <= contents of mem[address].
//     - data_out holds its value between edges. No read enable; a read occurs every cycle.
//   - Read during write, same address, same edge: write-first per byte.
//     - Enabled bytes of data_out take data_in.
//     - Disabled bytes take the stored (unchanged) value.
//     - So data_out always equals the post-write contents of the addressed word.
//   - write_enable=4'b0000 is a pure read. 4'b1111 is a full-word write.
//   - Address changes take effect at the next edge. No combinational path from any input to data_out.
//   - X/out-of-range: none possible; every address value is valid (full power-of-two depth).
//   - Reset mid-operation:
//     - A write on the same edge as rst assertion is dropped.
//     - After rst deasserts, the first edge resumes normal read/write.
//   - Synthesis: code the array so the tool infers block RAM with byte enables.
//     - Keep the read register as the RAM output register.
//     - Do not add an extra pipeline stage.
// TESTING
//   - Power-up read: assert/deassert rst, then read addr 0, 5 and 255 -> data_out = 32'h00000000
//     one cycle after each address is applied.
//   - Full write then read: write 32'hDEADBEEF to addr 3 (we=4'b1111), then read addr 3 with we=0
//     -> data_out = 32'hDEADBEEF after the write edge and after the read edge.
//   - Byte merge:
//     - Addr 3 holds 32'hDEADBEEF. Write data_in=32'h11223344, we=4'b0101.
//     - Result: data_out = 32'hDE22BE44 on that edge; later reads of addr 3 return the same.
//   - Independent addresses:
//     - Write 32'hAAAA0001 to addr 1 and 32'hBBBB0002 to addr 2.
//     - Alternate reads 1,2,1 -> 32'hAAAA0001, 32'hBBBB0002, 32'hAAAA0001, each 1 cycle late.
//   - Reset behaviour:
//     - With data_out = 32'hBBBB0002, assert rst mid-cycle -> data_out = 0 immediately.
//     - Write addr 2 with we=4'b1111 while rst=1 -> write dropped.
//     - After deassert, read addr 2 -> 32'hBBBB0002.
//   - Top address wrap: write 32'hCAFEF00D to addr 255 (AddressBitWidth=8) -> readback exact,
//     and addr 0 is unchanged (still its prior value).

Source files
------------

// File: rtl/byte_enabled_sdp_bram.sv
`default_nettype none
// ============================================================================
// Module      : byte_enabled_sdp_bram
// Description : Semi-dual-port block RAM, 2**AddressBitWidth x 32 bits, with
//               per-byte write enables, one shared address and a registered,
//               write-first read port. The array powers up cleared and is
//               never touched by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_enabled_sdp_bram #(
  parameter int AddressBitWidth = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 write_enable,
  input  logic [AddressBitWidth-1:0] address,
  input  logic [31:0]                data_in,
  output logic [31:0]                data_out
);

  localparam int c_DEPTH = 2 ** AddressBitWidth;

  // Power-up contents are zero; the cache depends on this for its
  // valid/dirty bits, so the initializer must reach the bitstream.
  logic [31:0] mem_q [0:c_DEPTH-1] = '{default: 32'h0};

  logic [31:0] data_out_q;
  logic [31:0] data_out_d;

  // Post-write view of the addressed word: enabled bytes come from data_in,
  // the rest from the stored word. This gives write-first per byte.
  always_comb begin
    data_out_d = mem_q[address];
    for (int i = 0; i < 4; i++) begin
      if (write_enable[i]) begin
        data_out_d[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  // Byte-enabled array write; writes are dropped while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (write_enable[i]) begin
          mem_q[address][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  // RAM output register: cleared asynchronously, otherwise loads every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= 32'h0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_enabled_sdp_bram.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_enabled_sdp_bram
// Description : Directed self-checking bench for byte_enabled_sdp_bram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_enabled_sdp_bram;

  logic        clk;
  logic        rst;
  logic [3:0]  write_enable;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int total_cnt;
  int bad_cnt;

  byte_enabled_sdp_bram #(
    .AddressBitWidth(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] we, input logic [7:0] a, input logic [31:0] d);
    write_enable = we;
    address      = a;
    data_in      = d;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst = 1'b1;
    drive(4'b0000, 8'd0, 32'h0);
    tick();
    tick();
    check("reset_out", data_out, 32'h0);
    rst = 1'b0;

    // Power-up contents are zero
    drive(4'b0000, 8'd0, 32'hFFFF_FFFF);   tick(); check("pwr_addr0", data_out, 32'h0);
    drive(4'b0000, 8'd5, 32'hFFFF_FFFF);   tick(); check("pwr_addr5", data_out, 32'h0);
    drive(4'b0000, 8'd255, 32'hFFFF_FFFF); tick(); check("pwr_addr255", data_out, 32'h0);

    // Full-word write, write-first on the same edge, then a pure read
    drive(4'b1111, 8'd3, 32'hDEAD_BEEF); tick(); check("full_wr_first", data_out, 32'hDEAD_BEEF);
    drive(4'b0000, 8'd3, 32'h0);         tick(); check("full_rd", data_out, 32'hDEAD_BEEF);

    // Byte merge
    drive(4'b0101, 8'd3, 32'h1122_3344); tick(); check("merge_wr_first", data_out, 32'hDE22_BE44);
    drive(4'b0000, 8'd3, 32'h5555_5555); tick(); check("merge_rd", data_out, 32'hDE22_BE44);

    // Upper-byte-only merge
    drive(4'b1000, 8'd3, 32'h99AA_BBCC); tick(); check("merge_hi_first", data_out, 32'h9922_BE44);

    // Independent addresses
    drive(4'b1111, 8'd1, 32'hAAAA_0001); tick(); check("wr_a1", data_out, 32'hAAAA_0001);
    drive(4'b1111, 8'd2, 32'hBBBB_0002); tick(); check("wr_a2", data_out, 32'hBBBB_0002);
    drive(4'b0000, 8'd1, 32'h0); tick(); check("rd_a1", data_out, 32'hAAAA_0001);
    drive(4'b0000, 8'd2, 32'h0); tick(); check("rd_a2", data_out, 32'hBBBB_0002);
    drive(4'b0000, 8'd1, 32'h0); tick(); check("rd_a1_again", data_out, 32'hAAAA_0001);
    drive(4'b0000, 8'd2, 32'h0); tick(); check("rd_a2_again", data_out, 32'hBBBB_0002);

    // Address change does not reach the output before the next edge
    drive(4'b0000, 8'd1, 32'h0); #2; check("no_comb_path", data_out, 32'hBBBB_0002);

    // Mid-cycle reset clears output immediately; write under reset dropped
    rst = 1'b1; #1; check("rst_async", data_out, 32'h0);
    drive(4'b1111, 8'd2, 32'h1234_5678); tick(); check("rst_hold", data_out, 32'h0);
    @(negedge clk); rst = 1'b0;
    drive(4'b0000, 8'd2, 32'h0); tick(); check("rst_wr_dropped", data_out, 32'hBBBB_0002);

    // Top address
    drive(4'b1111, 8'd255, 32'hCAFE_F00D); tick(); check("top_wr_first", data_out, 32'hCAFE_F00D);
    drive(4'b0000, 8'd255, 32'h0);         tick(); check("top_rd", data_out, 32'hCAFE_F00D);
    drive(4'b0000, 8'd0, 32'h0);           tick(); check("addr0_unchanged", data_out, 32'h0);
    drive(4'b0000, 8'd3, 32'h0);           tick(); check("addr3_kept", data_out, 32'h9922_BE44);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
